// File: rtl/perf_monitor_if.sv
// rtl/perf_monitor_if.sv - control/status bundle between the CPU top and perf_monitor
// Trace ports exist only when PERF_MONITOR_PC_TRACE_EN is defined.
interface perf_monitor_if #(
    parameter int CW = 32
);
    logic          start_i;
    logic          clear_i;
    logic          stall_i;
    logic          flush_i;
    logic [31:0]   pc_i;
    logic [CW-1:0] cycle_o;
    logic [CW-1:0] stall_cnt_o;
    logic [CW-1:0] flush_cnt_o;
    logic          running_o;
    logic          done_o;
`ifdef PERF_MONITOR_PC_TRACE_EN
    logic          trace_rd_i;
    logic [31:0]   trace_pc_o;
    logic          trace_empty_o;
`endif

    modport master (
        output start_i, clear_i, stall_i, flush_i, pc_i,
`ifdef PERF_MONITOR_PC_TRACE_EN
        output trace_rd_i,
        input  trace_pc_o, trace_empty_o,
`endif
        input  cycle_o, stall_cnt_o, flush_cnt_o, running_o, done_o
    );

    modport slave (
        input  start_i, clear_i, stall_i, flush_i, pc_i,
`ifdef PERF_MONITOR_PC_TRACE_EN
        input  trace_rd_i,
        output trace_pc_o, trace_empty_o,
`endif
        output cycle_o, stall_cnt_o, flush_cnt_o, running_o, done_o
    );
endinterface

// File: rtl/perf_monitor.sv
// rtl/perf_monitor.sv - cycle/stall/flush performance counters with IDLE/RUN/HALT control
// Optional 8-entry PC trace FIFO enabled by defining PERF_MONITOR_PC_TRACE_EN.
module perf_monitor #(
    parameter int CYCLE_LIMIT = 64,
    parameter int CW          = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    perf_monitor_if.slave mon
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    localparam logic [CW-1:0] ONES  = '1;
    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] LIMIT = CW'(CYCLE_LIMIT);
    // A limit wider than the counter can never be matched; the counters just saturate.
    localparam bit LIMIT_REACHABLE = ($clog2(CYCLE_LIMIT + 1) <= CW);

    state_t        state_q, state_d;
    logic [CW-1:0] cycle_q, cycle_d;
    logic [CW-1:0] stall_q, stall_d;
    logic [CW-1:0] flush_q, flush_d;
    logic          running_q;
    logic          done_q, done_d;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == ONES) ? v : v + ONE;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cycle_q   <= '0;
            stall_q   <= '0;
            flush_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cycle_q   <= cycle_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
            running_q <= (state_d == RUN);
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cycle_d = cycle_q;
        stall_d = stall_q;
        flush_d = flush_q;
        done_d  = 1'b0;
        if (mon.clear_i) begin
            state_d = IDLE;
            cycle_d = '0;
            stall_d = '0;
            flush_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mon.start_i) begin
                        if (CYCLE_LIMIT == 0) begin
                            state_d = HALT;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    // start_i low pauses in RUN with all counters held.
                    if (mon.start_i) begin
                        cycle_d = sat_inc(cycle_q);
                        if (mon.stall_i) stall_d = sat_inc(stall_q);
                        if (mon.flush_i) flush_d = sat_inc(flush_q);
                        if (LIMIT_REACHABLE && (cycle_d == LIMIT)) begin
                            state_d = HALT;
                            done_d  = 1'b1;
                        end
                    end
                end
                HALT: state_d = HALT;
                default: state_d = IDLE;
            endcase
        end
    end

    assign mon.cycle_o     = cycle_q;
    assign mon.stall_cnt_o = stall_q;
    assign mon.flush_cnt_o = flush_q;
    assign mon.running_o   = running_q;
    assign mon.done_o      = done_q;

`ifdef PERF_MONITOR_PC_TRACE_EN
    logic [31:0] fifo_q [8];
    logic [2:0]  wr_ptr_q, rd_ptr_q;
    logic [3:0]  count_q;
    logic [31:0] last_pc_q;
    logic        last_valid_q;
    logic        capture, pop, full;

    assign capture = (state_q == RUN) && mon.start_i && !mon.clear_i &&
                     (!last_valid_q || (mon.pc_i != last_pc_q));
    assign pop     = mon.trace_rd_i && (count_q != 4'd0);
    assign full    = (count_q == 4'd8);

    always_ff @(posedge clk_i) begin
        if (capture) fifo_q[wr_ptr_q] <= mon.pc_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            last_pc_q    <= '0;
            last_valid_q <= 1'b0;
        end else if (mon.clear_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            last_pc_q    <= '0;
            last_valid_q <= 1'b0;
        end else begin
            if (capture) begin
                wr_ptr_q     <= wr_ptr_q + 3'd1;
                last_pc_q    <= mon.pc_i;
                last_valid_q <= 1'b1;
            end
            // A push into a full FIFO drops the oldest entry, same as a pop.
            if (pop || (capture && full)) rd_ptr_q <= rd_ptr_q + 3'd1;
            if (capture && !pop && !full) count_q <= count_q + 4'd1;
            else if (pop && !capture)     count_q <= count_q - 4'd1;
        end
    end

    assign mon.trace_pc_o    = (count_q == 4'd0) ? 32'd0 : fifo_q[rd_ptr_q];
    assign mon.trace_empty_o = (count_q == 4'd0);
`else
    logic unused_pc;
    assign unused_pc = ^mon.pc_i;
`endif
endmodule

// File: tb/tb_perf_monitor.sv
// tb/tb_perf_monitor.sv - randomized self-checking bench for perf_monitor against a counting model
// Trace checks are built only when PERF_MONITOR_PC_TRACE_EN is defined.
module tb_perf_monitor;
    logic        clk = 1'b0;
    logic        rst;
    logic        start, clear, stall, flush;
    logic [31:0] pc;
    logic        trace_rd;

    int errors = 0;
    int checks = 0;

    // Model state per DUT: phase 0 idle, 1 running, 2 halted.
    longint lim  [3] = '{64, 0, 20};
    longint maxv [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
    longint m_cyc [3];
    longint m_st  [3];
    longint m_fl  [3];
    int     m_phase [3];
    bit     m_done  [3];
    int unsigned tq[$];
    int unsigned t_last;
    bit          t_last_v;

    perf_monitor_if #(.CW(32)) if0 ();
    perf_monitor_if #(.CW(32)) if1 ();
    perf_monitor_if #(.CW(4))  if2 ();

    assign {if0.start_i, if0.clear_i, if0.stall_i, if0.flush_i, if0.pc_i} = {start, clear, stall, flush, pc};
    assign {if1.start_i, if1.clear_i, if1.stall_i, if1.flush_i, if1.pc_i} = {start, clear, stall, flush, pc};
    assign {if2.start_i, if2.clear_i, if2.stall_i, if2.flush_i, if2.pc_i} = {start, clear, stall, flush, pc};
`ifdef PERF_MONITOR_PC_TRACE_EN
    assign if0.trace_rd_i = trace_rd;
    assign if1.trace_rd_i = 1'b0;
    assign if2.trace_rd_i = 1'b0;
`endif

    perf_monitor #(.CYCLE_LIMIT(64), .CW(32)) u_dut0 (.clk_i(clk), .rst_i(rst), .mon(if0));
    perf_monitor #(.CYCLE_LIMIT(0),  .CW(32)) u_dut1 (.clk_i(clk), .rst_i(rst), .mon(if1));
    perf_monitor #(.CYCLE_LIMIT(20), .CW(4))  u_dut2 (.clk_i(clk), .rst_i(rst), .mon(if2));

    logic [97:0] obs [3];
    assign obs[0] = {if0.cycle_o, if0.stall_cnt_o, if0.flush_cnt_o, if0.running_o, if0.done_o};
    assign obs[1] = {if1.cycle_o, if1.stall_cnt_o, if1.flush_cnt_o, if1.running_o, if1.done_o};
    assign obs[2] = {28'd0, if2.cycle_o, 28'd0, if2.stall_cnt_o, 28'd0, if2.flush_cnt_o, if2.running_o, if2.done_o};

    initial forever #5 clk = ~clk;

    function automatic logic [97:0] exp_vec(input int d);
        logic [31:0] c, s, f;
        c = 32'(m_cyc[d]);
        s = 32'(m_st[d]);
        f = 32'(m_fl[d]);
        return {c, s, f, (m_phase[d] == 1), m_done[d]};
    endfunction

    function automatic logic [32:0] exp_trace();
        return (tq.size() == 0) ? {1'b1, 32'd0} : {1'b0, tq[0]};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_cyc[d] = 0; m_st[d] = 0; m_fl[d] = 0; m_phase[d] = 0; m_done[d] = 0;
        end
        tq.delete();
        t_last_v = 0;
        t_last   = 0;
    endtask

    task automatic model_step();
        bit counted0;
        counted0 = (m_phase[0] == 1) && start && !clear;
        for (int d = 0; d < 3; d++) begin
            m_done[d] = 0;
            if (clear) begin
                m_phase[d] = 0; m_cyc[d] = 0; m_st[d] = 0; m_fl[d] = 0;
            end else if (m_phase[d] == 0 && start) begin
                if (lim[d] == 0) begin m_phase[d] = 2; m_done[d] = 1; end
                else m_phase[d] = 1;
            end else if (m_phase[d] == 1 && start) begin
                m_cyc[d] = (m_cyc[d] < maxv[d]) ? m_cyc[d] + 1 : maxv[d];
                if (stall) m_st[d] = (m_st[d] < maxv[d]) ? m_st[d] + 1 : maxv[d];
                if (flush) m_fl[d] = (m_fl[d] < maxv[d]) ? m_fl[d] + 1 : maxv[d];
                if (m_cyc[d] == lim[d]) begin m_phase[d] = 2; m_done[d] = 1; end
            end
        end
        if (clear) begin
            tq.delete();
            t_last_v = 0;
        end else begin
            if (trace_rd && tq.size() > 0) void'(tq.pop_front());
            if (counted0 && (!t_last_v || pc != t_last)) begin
                tq.push_back(pc);
                t_last   = pc;
                t_last_v = 1;
            end
            if (tq.size() > 8) void'(tq.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 0; clear = 0; stall = 0; flush = 0; pc = 0; trace_rd = 0;
        model_reset();
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (obs[d] !== 98'd0) begin errors++; $display("FAIL reset dut%0d: got %h expected 0", d, obs[d]); end
        end
`ifdef PERF_MONITOR_PC_TRACE_EN
        checks++;
        if ({if0.trace_empty_o, if0.trace_pc_o} !== {1'b1, 32'd0}) begin
            errors++; $display("FAIL reset_trace: got %b/%h expected 1/0", if0.trace_empty_o, if0.trace_pc_o);
        end
`endif
        rst = 1'b0;
        tick();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (obs[d] !== exp_vec(d)) begin errors++; $display("FAIL reset_idle dut%0d: got %h expected %h", d, obs[d], exp_vec(d)); end
        end
    endtask

    task automatic test_full_run();
        int dones = 0;
        start = 1'b1;
        for (int k = 0; k < 270; k++) begin
            tick();
            if (if0.done_o) dones++;
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (obs[d] !== exp_vec(d)) begin errors++; $display("FAIL full_run k%0d dut%0d: got %h expected %h", k, d, obs[d], exp_vec(d)); end
            end
        end
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL full_run_done_pulses: got %0d expected 1", dones); end
        checks++;
        if ({if0.cycle_o, if0.running_o} !== {32'd64, 1'b0}) begin
            errors++; $display("FAIL full_run_final: got cycle=%0d running=%b expected 64/0", if0.cycle_o, if0.running_o);
        end
        checks++;
        if ({if2.cycle_o, if2.running_o} !== {4'hF, 1'b1}) begin
            errors++; $display("FAIL saturate: got cycle=%0d running=%b expected 15/1", if2.cycle_o, if2.running_o);
        end
    endtask

    task automatic test_stall_flush();
        clear = 1'b1; stall = 0; flush = 0;
        tick();
        clear = 1'b0; start = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            stall = (i >= 2 && i <= 6);
            flush = (i >= 5 && i <= 7);
            tick();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (obs[d] !== exp_vec(d)) begin errors++; $display("FAIL stall_flush i%0d dut%0d: got %h expected %h", i, d, obs[d], exp_vec(d)); end
            end
        end
        stall = 0; flush = 0;
        checks++;
        if ({if0.stall_cnt_o, if0.flush_cnt_o} !== {32'd5, 32'd3}) begin
            errors++; $display("FAIL stall_flush_totals: got %0d/%0d expected 5/3", if0.stall_cnt_o, if0.flush_cnt_o);
        end
    endtask

    task automatic test_pause();
        int done_k = 0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int k = 1; k <= 200 && done_k == 0; k++) begin
            start = !(k >= 22 && k <= 31);
            tick();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (obs[d] !== exp_vec(d)) begin errors++; $display("FAIL pause k%0d dut%0d: got %h expected %h", k, d, obs[d], exp_vec(d)); end
            end
            if (if0.done_o) done_k = k;
        end
        start = 1'b1;
        checks++;
        if (done_k !== 75) begin errors++; $display("FAIL pause_halt_edge: got %0d expected 75", done_k); end
    endtask

    task automatic test_reset_mid();
        clear = 1'b1;
        tick();
        clear = 1'b0; start = 1'b1;
        for (int k = 0; k < 30; k++) tick();
        #2 rst = 1'b1;
        model_reset();
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (obs[d] !== 98'd0) begin errors++; $display("FAIL reset_mid dut%0d: got %h expected 0", d, obs[d]); end
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (obs[d] !== exp_vec(d)) begin errors++; $display("FAIL reset_restart k%0d dut%0d: got %h expected %h", k, d, obs[d], exp_vec(d)); end
            end
        end
        checks++;
        if (if0.cycle_o !== 32'd9) begin errors++; $display("FAIL reset_restart_count: got %0d expected 9", if0.cycle_o); end
    endtask

    task automatic test_clear_rerun();
        bit sb [100];
        bit fb [100];
        int done_k;
        for (int i = 0; i < 100; i++) begin
            sb[i] = $urandom_range(0, 1);
            fb[i] = $urandom_range(0, 1);
        end
        start = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int run = 0; run < 2; run++) begin
            done_k = 0;
            for (int k = 1; k < 100; k++) begin
                stall = sb[k]; flush = fb[k];
                tick();
                if (if0.done_o) done_k = k;
            end
            stall = 0; flush = 0;
            checks++;
            if (done_k !== 65) begin errors++; $display("FAIL rerun%0d_halt_edge: got %0d expected 65", run, done_k); end
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (obs[d] !== exp_vec(d)) begin errors++; $display("FAIL rerun%0d dut%0d: got %h expected %h", run, d, obs[d], exp_vec(d)); end
            end
            clear = 1'b1;
            tick();
            clear = 1'b0;
            checks++;
            if (obs[0] !== 98'd0) begin errors++; $display("FAIL clear_in_halt run%0d: got %h expected 0", run, obs[0]); end
        end
    endtask

`ifdef PERF_MONITOR_PC_TRACE_EN
    task automatic test_trace();
        clear = 1'b1; trace_rd = 0; stall = 0; flush = 0;
        tick();
        clear = 1'b0; start = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            pc = i * 4;
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({if0.trace_empty_o, if0.trace_pc_o} !== {1'b0, 32'(16 + 4 * i)}) begin
                errors++; $display("FAIL trace_read%0d: got %b/%0d expected 0/%0d", i, if0.trace_empty_o, if0.trace_pc_o, 16 + 4 * i);
            end
            trace_rd = 1'b1;
            tick();
        end
        trace_rd = 1'b0;
        checks++;
        if ({if0.trace_empty_o, if0.trace_pc_o} !== {1'b1, 32'd0}) begin
            errors++; $display("FAIL trace_drained: got %b/%h expected 1/0", if0.trace_empty_o, if0.trace_pc_o);
        end
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            start    = ($urandom_range(0, 7) != 0);
            clear    = ($urandom_range(0, 39) == 0);
            stall    = $urandom_range(0, 1);
            flush    = $urandom_range(0, 1);
            pc       = $urandom_range(0, 3) * 4;
            trace_rd = ($urandom_range(0, 2) == 0);
            tick();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (obs[d] !== exp_vec(d)) begin errors++; $display("FAIL random k%0d dut%0d: got %h expected %h", k, d, obs[d], exp_vec(d)); end
            end
`ifdef PERF_MONITOR_PC_TRACE_EN
            checks++;
            if ({if0.trace_empty_o, if0.trace_pc_o} !== exp_trace()) begin
                errors++; $display("FAIL random_trace k%0d: got %b/%h expected %h", k, if0.trace_empty_o, if0.trace_pc_o, exp_trace());
            end
`endif
        end
        clear = 0; trace_rd = 0;
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_stall_flush();
        test_pause();
        test_reset_mid();
        test_clear_rerun();
`ifdef PERF_MONITOR_PC_TRACE_EN
        test_trace();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/perf_monitor.md
PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 Parameter CYCLE_LIMIT, default 64, number of counted cycles after which counting halts.
REQ-002 Parameter CW, default 32, counter width in bits.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 start_i  input  1  level enable from the CPU top; counting only while high.
REQ-006 clear_i  input  1  synchronous clear of counters and state to IDLE.
REQ-007 stall_i  input  1  pipeline hazard-stall indication for this cycle.
REQ-008 flush_i  input  1  branch/jump flush indication for this cycle.
REQ-009 pc_i  input  32  current PC value.
REQ-010 cycle_o, stall_cnt_o, flush_cnt_o  output  CW each  cycle, stall and flush counts.
REQ-011 running_o  output  1  high in RUN.
REQ-012 done_o  output  1  one-cycle pulse on entry to HALT.

Function
REQ-013 FSM states: IDLE, RUN, HALT.
REQ-014 IDLE->RUN on the first rising edge with start_i=1; no counting on that edge.
REQ-015 In RUN, on each edge: cycle_o+1; stall_cnt_o+1 if stall_i; flush_cnt_o+1 if flush_i.
REQ-016 stall_i and flush_i high on the same edge: both counters increment.
REQ-017 In RUN with start_i=0: hold all counters, remain in RUN (pause), running_o stays 1.
REQ-018 RUN->HALT on the edge where cycle_o becomes CYCLE_LIMIT; done_o=1 for exactly the following cycle.
REQ-019 In HALT, counters frozen; state left only by clear_i or rst_i.
REQ-020 clear_i has priority over all counting: next edge -> IDLE, counters 0, done_o 0.
REQ-021 Counters saturate at all-ones (relevant when CYCLE_LIMIT >= 2^CW); no wrap.
REQ-022 CYCLE_LIMIT=0: IDLE->HALT directly on the first start_i edge, done_o pulses, counts 0.
REQ-023 Outputs are registered; counter values visible the cycle after the counted edge.

Reset
REQ-024 rst_i=1 immediately forces IDLE, all counters 0, running_o 0, done_o 0, trace buffer empty, regardless of clock.
REQ-025 Reset asserted mid-RUN discards all counts; after release behaves as from power-up.

Configuration
REQ-026 Macro PERF_MONITOR_PC_TRACE_EN.
REQ-027 Defined: adds ports trace_rd_i (in, 1), trace_pc_o (out, 32), trace_empty_o (out, 1); 8-entry FIFO captures pc_i on every counted RUN edge where pc_i differs from the last captured value.
REQ-028 FIFO full and new capture: oldest entry overwritten (read pointer advances); trace_pc_o shows the oldest entry combinationally; trace_rd_i pops when not empty, ignored when empty; simultaneous push and pop on a full FIFO: pop oldest, push new, count unchanged.
REQ-029 FIFO is cleared by rst_i and clear_i; reset value trace_empty_o=1, trace_pc_o=0.
REQ-030 Not defined: trace ports and FIFO absent; all other behaviour identical.

Verification
REQ-031 start_i=1 constant, stall_i=flush_i=0, CYCLE_LIMIT=64 -> cycle_o reaches 64, done_o single pulse, running_o falls, counts held 200 more cycles.
REQ-032 stall_i high 5 cycles, flush_i high 3 cycles, 2 of them overlapping -> stall_cnt_o=5, flush_cnt_o=3.
REQ-033 start_i low 10 cycles at cycle 20 -> counters hold, HALT reached 10 cycles later than without pause.
REQ-034 rst_i asserted between clock edges at cycle 30 -> outputs 0 immediately, restart counts from 0.
REQ-035 clear_i in HALT -> IDLE, counts 0, restart on start_i yields identical second run.
REQ-036 With PERF_MONITOR_PC_TRACE_EN: pc_i = 0,4,8,...,44 (12 values), no reads -> reads return 16,20,...,44 then trace_empty_o=1.
